// File: rtl/mcp3202_responder.sv
// MCP3202-compatible SPI responder; MCP3202_LSB_TAIL_EN enables the LSB-first repeat after B0.
// MISO/MISO_oe follow a pin edge by SYNC_STAGES+1 clocks; no backpressure, the master sets the pace.
module mcp3202_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        nCS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [11:0] ch0_data,
  input  logic [11:0] ch1_data,
  output logic        conv_strobe,
  output logic        conv_ch,
  output logic        conv_diff,
  output logic        frame_abort
);

  typedef enum logic [3:0] {
    IDLE,
    WAIT_START,
    GET_SGL,
    GET_ODD,
    GET_MSBF,
    NULL_OUT,
    DATA_OUT,
    TRAIL
`ifdef MCP3202_LSB_TAIL_EN
    , LSB_TAIL
`endif
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_s;
  logic                   ncs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;

  state_t      state_q, state_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic [11:0] shreg_q, shreg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sgl_q, sgl_d;
  logic        odd_q, odd_d;
  logic        conv_ch_q, conv_ch_d;
  logic        conv_diff_q, conv_diff_d;
  logic        strobe_q, strobe_d;
  logic        abort_q, abort_d;
`ifdef MCP3202_LSB_TAIL_EN
  logic        msbf_q, msbf_d;
`endif

  logic signed [12:0] diff01;
  logic signed [12:0] diff10;
  logic [11:0]        result;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ncs_sync  <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  // Zero-extended 13-bit signed difference; a set sign bit means the result clamps to zero.
  assign diff01 = $signed({1'b0, ch0_data}) - $signed({1'b0, ch1_data});
  assign diff10 = $signed({1'b0, ch1_data}) - $signed({1'b0, ch0_data});

  always_comb begin
    result = ch0_data;
    if (sgl_q) begin
      result = odd_q ? ch1_data : ch0_data;
    end else if (odd_q) begin
      result = diff10[12] ? 12'd0 : diff10[11:0];
    end else begin
      result = diff01[12] ? 12'd0 : diff01[11:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      shreg_q     <= 12'd0;
      cnt_q       <= 4'd0;
      sgl_q       <= 1'b0;
      odd_q       <= 1'b0;
      conv_ch_q   <= 1'b0;
      conv_diff_q <= 1'b0;
      strobe_q    <= 1'b0;
      abort_q     <= 1'b0;
`ifdef MCP3202_LSB_TAIL_EN
      msbf_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      sgl_q       <= sgl_d;
      odd_q       <= odd_d;
      conv_ch_q   <= conv_ch_d;
      conv_diff_q <= conv_diff_d;
      strobe_q    <= strobe_d;
      abort_q     <= abort_d;
`ifdef MCP3202_LSB_TAIL_EN
      msbf_q      <= msbf_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    sgl_d       = sgl_q;
    odd_d       = odd_q;
    conv_ch_d   = conv_ch_q;
    conv_diff_d = conv_diff_q;
    strobe_d    = 1'b0;
    abort_d     = 1'b0;
`ifdef MCP3202_LSB_TAIL_EN
    msbf_d      = msbf_q;
`endif
    // Deselect wins over any SCLK edge seen in the same cycle.
    if (ncs_s && (state_q != IDLE)) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      oe_d    = 1'b0;
      abort_d = (state_q == GET_SGL) || (state_q == GET_ODD) || (state_q == GET_MSBF) ||
                (state_q == NULL_OUT) || (state_q == DATA_OUT);
    end else begin
      case (state_q)
        IDLE: begin
          if (!ncs_s) state_d = WAIT_START;
        end
        WAIT_START: begin
          if (sclk_rise && mosi_s) state_d = GET_SGL;
        end
        GET_SGL: begin
          if (sclk_rise) begin
            sgl_d   = mosi_s;
            state_d = GET_ODD;
          end
        end
        GET_ODD: begin
          if (sclk_rise) begin
            odd_d   = mosi_s;
            state_d = GET_MSBF;
          end
        end
        GET_MSBF: begin
          if (sclk_rise) begin
`ifdef MCP3202_LSB_TAIL_EN
            msbf_d  = mosi_s;
`endif
            state_d = NULL_OUT;
          end
        end
        NULL_OUT: begin
          if (sclk_fall) begin
            shreg_d     = result;
            strobe_d    = 1'b1;
            conv_ch_d   = odd_q;
            conv_diff_d = ~sgl_q;
            miso_d      = 1'b0;
            oe_d        = 1'b1;
            cnt_d       = 4'd11;
            state_d     = DATA_OUT;
          end
        end
        DATA_OUT: begin
          if (sclk_fall) begin
            miso_d = shreg_q[cnt_q];
            if (cnt_q == 4'd0) begin
`ifdef MCP3202_LSB_TAIL_EN
              if (!msbf_q) begin
                cnt_d   = 4'd1;
                state_d = LSB_TAIL;
              end else begin
                state_d = TRAIL;
              end
`else
              state_d = TRAIL;
`endif
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
`ifdef MCP3202_LSB_TAIL_EN
        LSB_TAIL: begin
          if (sclk_fall) begin
            miso_d = shreg_q[cnt_q];
            if (cnt_q == 4'd11) begin
              state_d = TRAIL;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
`endif
        TRAIL: begin
          if (sclk_fall) miso_d = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign MISO        = miso_q;
  assign MISO_oe     = oe_q;
  assign conv_strobe = strobe_q;
  assign conv_ch     = conv_ch_q;
  assign conv_diff   = conv_diff_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_mcp3202_responder.sv
// Bench for mcp3202_responder: directed SPI frames with a queue-based scoreboard per output stream.
module tb_mcp3202_responder;

  localparam int SYNC = 2;
`ifdef MCP3202_LSB_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        SCLK;
  logic        nCS;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;
  logic [11:0] ch0_data;
  logic [11:0] ch1_data;
  logic        conv_strobe;
  logic        conv_ch;
  logic        conv_diff;
  logic        frame_abort;

  int errors = 0;
  int checks = 0;

  bit       exp_bits[$];
  bit [1:0] exp_conv[$];
  bit       exp_abort[$];

  mcp3202_responder #(.SYNC_STAGES(SYNC)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .SCLK       (SCLK),
    .nCS        (nCS),
    .MOSI       (MOSI),
    .MISO       (MISO),
    .MISO_oe    (MISO_oe),
    .ch0_data   (ch0_data),
    .ch1_data   (ch1_data),
    .conv_strobe(conv_strobe),
    .conv_ch    (conv_ch),
    .conv_diff  (conv_diff),
    .frame_abort(frame_abort)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected MISO at the k-th sampling rise after MSBF (k=0 is the null bit).
  function automatic bit exp_bit(input logic [11:0] v, input int k, input bit tail);
    if (k >= 1 && k <= 12) return v[12-k];
    if (tail && k >= 13 && k <= 23) return v[k-12];
    return 1'b0;
  endfunction

  initial begin : miso_monitor
    bit b;
    forever begin
      @(posedge SCLK);
      if (!nCS && MISO_oe) begin
        if (exp_bits.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected: MISO=%0b driven with no bit expected at %0t", MISO, $time);
        end else begin
          b = exp_bits.pop_front();
          check("miso_bit", 32'(MISO), 32'(b));
        end
      end
    end
  end

  initial begin : conv_monitor
    bit [1:0] e;
    forever begin
      @(negedge clock);
      if (conv_strobe) begin
        if (exp_conv.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL conv_unexpected: conv_strobe=1 with no conversion expected at %0t", $time);
        end else begin
          e = exp_conv.pop_front();
          check("conv_ch", 32'(conv_ch), 32'(e[1]));
          check("conv_diff", 32'(conv_diff), 32'(e[0]));
        end
        @(negedge clock);
        check("conv_strobe_width", 32'(conv_strobe), 32'd0);
      end
    end
  end

  initial begin : abort_monitor
    forever begin
      @(negedge clock);
      if (frame_abort) begin
        if (exp_abort.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL abort_unexpected: frame_abort=1 with no abort expected at %0t", $time);
        end else begin
          void'(exp_abort.pop_front());
          checks++;
        end
        @(negedge clock);
        check("abort_width", 32'(frame_abort), 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_miso"}, 32'(MISO), 32'd0);
    check({tag, "_miso_oe"}, 32'(MISO_oe), 32'd0);
    check({tag, "_conv_strobe"}, 32'(conv_strobe), 32'd0);
    check({tag, "_conv_ch"}, 32'(conv_ch), 32'd0);
    check({tag, "_conv_diff"}, 32'(conv_diff), 32'd0);
    check({tag, "_frame_abort"}, 32'(frame_abort), 32'd0);
  endtask

  // end_mode: 0 = normal deselect, 1 = deselect mid-data (abort), 2 = reset mid-frame.
  task automatic frame(input bit sgl, input bit odd, input bit msbf, input int lead0,
                       input int n_sclk, input logic [11:0] val, input int end_mode);
    int r;
    exp_conv.push_back({odd, ~sgl});
    @(negedge clock);
    nCS = 1'b0;
    repeat (8) @(negedge clock);
    for (int j = 0; j < lead0 + n_sclk; j++) begin
      r = j - lead0 + 1;
      case (r)
        1:       MOSI = 1'b1;
        2:       MOSI = sgl;
        3:       MOSI = odd;
        4:       MOSI = msbf;
        default: MOSI = 1'b0;
      endcase
      repeat (4) @(negedge clock);
      if (r >= 5) exp_bits.push_back(exp_bit(val, r - 5, TAIL_EN && !msbf));
      SCLK = 1'b1;
      repeat (8) @(negedge clock);
      SCLK = 1'b0;
      if (r == 8) begin
        ch0_data = ch0_data ^ 12'hFFF;
        ch1_data = ch1_data ^ 12'hFFF;
      end
      repeat (4) @(negedge clock);
    end
    if (end_mode == 1) begin
      exp_abort.push_back(1'b1);
      nCS = 1'b1;
      repeat (SYNC + 1) @(posedge clock);
      #1;
      check("abort_oe_off", 32'(MISO_oe), 32'd0);
      check("abort_miso_low", 32'(MISO), 32'd0);
      repeat (16) @(negedge clock);
    end else if (end_mode == 2) begin
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      nCS = 1'b1;
      repeat (4) @(negedge clock);
      reset_n = 1'b1;
      repeat (8) @(negedge clock);
    end else begin
      repeat (4) @(negedge clock);
      nCS = 1'b1;
      repeat (16) @(negedge clock);
    end
  endtask

  initial begin : stimulus
    reset_n  = 1'b0;
    SCLK     = 1'b0;
    nCS      = 1'b1;
    MOSI     = 1'b0;
    ch0_data = 12'h000;
    ch1_data = 12'h000;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    ch0_data = 12'h123; ch1_data = 12'hA5C;
    frame(1'b1, 1'b1, 1'b1, 0, 17, 12'hA5C, 0);
    ch0_data = 12'h001; ch1_data = 12'hFFF;
    frame(1'b1, 1'b0, 1'b1, 2, 18, 12'h001, 0);
    ch0_data = 12'h300; ch1_data = 12'h100;
    frame(1'b0, 1'b0, 1'b1, 0, 17, 12'h200, 0);
    ch0_data = 12'h100; ch1_data = 12'h300;
    frame(1'b0, 1'b0, 1'b1, 0, 17, 12'h000, 0);
    ch0_data = 12'h100; ch1_data = 12'h300;
    frame(1'b0, 1'b1, 1'b1, 0, 17, 12'h200, 0);
    ch0_data = 12'h000; ch1_data = 12'hA5C;
    frame(1'b1, 1'b1, 1'b1, 0, 10, 12'hA5C, 1);
    ch0_data = 12'h5A3; ch1_data = 12'h000;
    frame(1'b1, 1'b0, 1'b1, 0, 17, 12'h5A3, 0);
    ch0_data = 12'hC3C; ch1_data = 12'h000;
    frame(1'b1, 1'b0, 1'b1, 0, 9, 12'hC3C, 2);
    ch0_data = 12'h000; ch1_data = 12'h7E1;
    frame(1'b1, 1'b1, 1'b1, 0, 19, 12'h7E1, 0);
    ch0_data = 12'h801; ch1_data = 12'h000;
    frame(1'b1, 1'b0, 1'b0, 0, 30, 12'h801, 0);

    repeat (8) @(negedge clock);
    check("bits_outstanding", 32'(exp_bits.size()), 32'd0);
    check("conv_outstanding", 32'(exp_conv.size()), 32'd0);
    check("abort_outstanding", 32'(exp_abort.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
